// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - RISC-V immediate decode stage behind a 2-entry skid buffer
module imm_decode_stage #(
  parameter int XLEN   = 32,
  parameter int EN_CSR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal,
  output logic [31:0]     out_insn,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t      dec;
  logic [63:0] imm64;
  logic [2:0]  fmt;
  logic        illegal;
  logic        sx;

  // Immediates are built at 64 bits and truncated so one path serves both widths.
  always_comb begin
    sx      = in_insn[31];
    imm64   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (in_insn[6:0])
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111:             fmt = FMT_J;
      7'b1100111, 7'b0000011, 7'b0010011: fmt = FMT_I;
      7'b0011011: begin
        if (XLEN == 64) fmt = FMT_I;
        else            illegal = 1'b1;
      end
      7'b0100011:             fmt = FMT_S;
      7'b1100011:             fmt = FMT_B;
      7'b0110011, 7'b0001111: fmt = FMT_NONE;
      7'b0111011: begin
        if (XLEN != 64) illegal = 1'b1;
      end
      7'b1110011: begin
        if ((EN_CSR != 0) && in_insn[14]) fmt = FMT_Z;
      end
      default:                illegal = 1'b1;
    endcase

    case (fmt)
      FMT_I:   imm64 = {{52{sx}}, in_insn[31:20]};
      FMT_S:   imm64 = {{52{sx}}, in_insn[31:25], in_insn[11:7]};
      FMT_B:   imm64 = {{51{sx}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
      FMT_U:   imm64 = {{32{sx}}, in_insn[31:12], 12'b0};
      FMT_J:   imm64 = {{43{sx}}, in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
      FMT_Z:   imm64 = {59'b0, in_insn[19:15]};
      default: imm64 = '0;
    endcase

    dec.imm     = imm64[XLEN-1:0];
    dec.target  = in_pc + imm64[XLEN-1:0];
    dec.fmt     = fmt;
    dec.illegal = illegal;
    dec.insn    = in_insn;
    dec.pc      = in_pc;
  end

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   in_fire, out_fire;

  assign in_ready  = !skid_valid_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid_q && out_ready;

  // Skid is only filled while main is held, so main empty implies skid empty.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;
  assign out_insn    = main_q.insn;
  assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed vector bench for imm_decode_stage
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_insn, pc32;
  logic [63:0] pc64;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm, a_out_target, a_out_insn, a_out_pc;
  logic [2:0]  a_out_fmt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm, b_out_target, b_out_pc;
  logic [31:0] b_out_insn;
  logic [2:0]  b_out_fmt;

  logic        c_in_ready, c_out_valid, c_out_illegal;
  logic [31:0] c_out_imm, c_out_target, c_out_insn, c_out_pc;
  logic [2:0]  c_out_fmt;

  imm_decode_stage #(.XLEN(32), .EN_CSR(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_insn(in_insn), .in_pc(pc32), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_target(a_out_target),
    .out_illegal(a_out_illegal), .out_insn(a_out_insn), .out_pc(a_out_pc));

  imm_decode_stage #(.XLEN(64), .EN_CSR(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_insn(in_insn), .in_pc(pc64), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_target(b_out_target),
    .out_illegal(b_out_illegal), .out_insn(b_out_insn), .out_pc(b_out_pc));

  imm_decode_stage #(.XLEN(32), .EN_CSR(0)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_insn(in_insn), .in_pc(pc32), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_imm(c_out_imm), .out_fmt(c_out_fmt), .out_target(c_out_target),
    .out_illegal(c_out_illegal), .out_insn(c_out_insn), .out_pc(c_out_pc));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc);
    in_insn = insn;
    pc32    = pc;
    pc64    = {32'b0, pc};
  endtask

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [2:0]  f32;
    logic        i32;
    logic [31:0] m32;
    logic [31:0] t32;
    logic [2:0]  f64;
    logic        i64;
    logic [63:0] m64;
    logic [63:0] t64;
    logic [2:0]  fc;
    logic        ic;
    logic [31:0] mc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'h100,      3'd1, 1'b0, 32'hFFFFFFFF, 32'h000000FF,
                 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h00000000000000FF, 3'd1, 1'b0, 32'hFFFFFFFF};
    vecs[1]  = '{32'h3400D073, 32'h0,        3'd6, 1'b0, 32'h00000001, 32'h00000001,
                 3'd6, 1'b0, 64'h1, 64'h1, 3'd0, 1'b0, 32'h0};
    vecs[2]  = '{32'h0000007F, 32'h40,       3'd0, 1'b1, 32'h0, 32'h40,
                 3'd0, 1'b1, 64'h0, 64'h40, 3'd0, 1'b1, 32'h0};
    vecs[3]  = '{32'h00000010, 32'h8,        3'd0, 1'b1, 32'h0, 32'h8,
                 3'd0, 1'b1, 64'h0, 64'h8, 3'd0, 1'b1, 32'h0};
    vecs[4]  = '{32'hFE20AE23, 32'h200,      3'd2, 1'b0, 32'hFFFFFFFC, 32'h000001FC,
                 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h1FC, 3'd2, 1'b0, 32'hFFFFFFFC};
    vecs[5]  = '{32'hFE000EE3, 32'h1000,     3'd3, 1'b0, 32'hFFFFFFFC, 32'h00000FFC,
                 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'hFFC, 3'd3, 1'b0, 32'hFFFFFFFC};
    vecs[6]  = '{32'h12345097, 32'h10,       3'd4, 1'b0, 32'h12345000, 32'h12345010,
                 3'd4, 1'b0, 64'h12345000, 64'h12345010, 3'd4, 1'b0, 32'h12345000};
    vecs[7]  = '{32'h800000B7, 32'h90000000, 3'd4, 1'b0, 32'h80000000, 32'h10000000,
                 3'd4, 1'b0, 64'hFFFFFFFF80000000, 64'h10000000, 3'd4, 1'b0, 32'h80000000};
    vecs[8]  = '{32'h008000EF, 32'h300,      3'd5, 1'b0, 32'h8, 32'h308,
                 3'd5, 1'b0, 64'h8, 64'h308, 3'd5, 1'b0, 32'h8};
    vecs[9]  = '{32'hFF9FF06F, 32'h400,      3'd5, 1'b0, 32'hFFFFFFF8, 32'h3F8,
                 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h3F8, 3'd5, 1'b0, 32'hFFFFFFF8};
    vecs[10] = '{32'h00000033, 32'h20,       3'd0, 1'b0, 32'h0, 32'h20,
                 3'd0, 1'b0, 64'h0, 64'h20, 3'd0, 1'b0, 32'h0};
    vecs[11] = '{32'h0000001B, 32'h30,       3'd0, 1'b1, 32'h0, 32'h30,
                 3'd1, 1'b0, 64'h0, 64'h30, 3'd0, 1'b1, 32'h0};
    vecs[12] = '{32'h0000003B, 32'h34,       3'd0, 1'b1, 32'h0, 32'h34,
                 3'd0, 1'b0, 64'h0, 64'h34, 3'd0, 1'b1, 32'h0};
    vecs[13] = '{32'h00000073, 32'h50,       3'd0, 1'b0, 32'h0, 32'h50,
                 3'd0, 1'b0, 64'h0, 64'h50, 3'd0, 1'b0, 32'h0};
    vecs[14] = '{32'h80002083, 32'h1000,     3'd1, 1'b0, 32'hFFFFF800, 32'h800,
                 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 64'h800, 3'd1, 1'b0, 32'hFFFFF800};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 32'h0);
    step(); step();
    rst = 1'b0;
    chk("reset_out_valid", a_out_valid, 0);
    chk("reset_in_ready",  a_in_ready,  1);
    chk("reset_imm",       a_out_imm,   0);
    chk("reset_fmt64",     b_out_fmt,   0);

    // Streaming: one transfer in and one out every cycle, occupancy stays at one.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].insn, vecs[i].pc);
      step();
      chk($sformatf("v%0d_valid",  i), a_out_valid,   1);
      chk($sformatf("v%0d_ready",  i), a_in_ready,    1);
      chk($sformatf("v%0d_fmt32",  i), a_out_fmt,     vecs[i].f32);
      chk($sformatf("v%0d_ill32",  i), a_out_illegal, vecs[i].i32);
      chk($sformatf("v%0d_imm32",  i), a_out_imm,     vecs[i].m32);
      chk($sformatf("v%0d_tgt32",  i), a_out_target,  vecs[i].t32);
      chk($sformatf("v%0d_insn32", i), a_out_insn,    vecs[i].insn);
      chk($sformatf("v%0d_pc32",   i), a_out_pc,      vecs[i].pc);
      chk($sformatf("v%0d_fmt64",  i), b_out_fmt,     vecs[i].f64);
      chk($sformatf("v%0d_ill64",  i), b_out_illegal, vecs[i].i64);
      chk($sformatf("v%0d_imm64",  i), b_out_imm,     vecs[i].m64);
      chk($sformatf("v%0d_tgt64",  i), b_out_target,  vecs[i].t64);
      chk($sformatf("v%0d_fmtc0",  i), c_out_fmt,     vecs[i].fc);
      chk($sformatf("v%0d_illc0",  i), c_out_illegal, vecs[i].ic);
      chk($sformatf("v%0d_immc0",  i), c_out_imm,     vecs[i].mc);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", a_out_valid, 0);

    // Backpressure: two accepted, third stalls, then drains in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(vecs[0].insn, vecs[0].pc);
    step();
    chk("bp_a_valid", a_out_valid, 1);
    chk("bp_a_ready", a_in_ready,  1);
    drive(vecs[4].insn, vecs[4].pc);
    step();
    chk("bp_b_ready", a_in_ready, 0);
    chk("bp_b_hold",  a_out_insn, vecs[0].insn);
    drive(vecs[5].insn, vecs[5].pc);
    step();
    chk("bp_c_ready", a_in_ready, 0);
    chk("bp_c_hold",  a_out_insn, vecs[0].insn);
    chk("bp_c_imm",   a_out_imm,  vecs[0].m32);
    out_ready = 1'b1;
    step();
    chk("bp_out_b",   a_out_insn,  vecs[4].insn);
    chk("bp_out_b_v", a_out_valid, 1);
    chk("bp_rearm",   a_in_ready,  1);
    chk("bp_out_b64", b_out_imm,   vecs[4].m64);
    step();
    in_valid = 1'b0;
    chk("bp_out_c",   a_out_insn,  vecs[5].insn);
    chk("bp_out_c_v", a_out_valid, 1);
    step();
    chk("bp_empty",   a_out_valid, 0);

    // Flush with both entries held plus one offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(vecs[6].insn, vecs[6].pc);
    step();
    drive(vecs[8].insn, vecs[8].pc);
    step();
    drive(vecs[9].insn, vecs[9].pc);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", a_out_valid, 0);
    chk("fl_ready", a_in_ready,  1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_ghost%0d", k), a_out_valid, 0);
    end
    in_valid = 1'b1;
    flush    = 1'b1;
    drive(vecs[0].insn, vecs[0].pc);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_same_cycle", a_out_valid, 0);

    // Reset mid-stream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(vecs[4].insn, vecs[4].pc);
    step();
    drive(vecs[5].insn, vecs[5].pc);
    step();
    drive(vecs[6].insn, vecs[6].pc);
    rst   = 1'b1;
    flush = 1'b1;
    step();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("rs_valid",  a_out_valid,   0);
    chk("rs_ready",  a_in_ready,    1);
    chk("rs_imm",    a_out_imm,     0);
    chk("rs_tgt",    a_out_target,  0);
    chk("rs_fmt",    a_out_fmt,     0);
    chk("rs_ill",    a_out_illegal, 0);
    chk("rs_insn",   a_out_insn,    0);
    chk("rs_pc",     a_out_pc,      0);
    chk("rs_imm64",  b_out_imm,     0);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("rs_ghost%0d", k), a_out_valid, 0);
    end
    in_valid = 1'b1;
    drive(vecs[14].insn, vecs[14].pc);
    step();
    in_valid = 1'b0;
    chk("rs_fresh_insn", a_out_insn, vecs[14].insn);
    chk("rs_fresh_imm",  a_out_imm,  vecs[14].m32);
    step();
    chk("rs_fresh_gone", a_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 and 64.
REQ-002 The block SHALL have parameter EN_CSR, default 1, meaning that when 1 the CSR zimm format is decoded.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream offers an instruction.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts this cycle.
REQ-008 The block SHALL have port in_insn, input, 32 bits: instruction word.
REQ-009 The block SHALL have port in_pc, input, XLEN bits: address of the instruction.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-012 The block SHALL have port out_imm, output, XLEN bits: sign-extended immediate.
REQ-013 The block SHALL have port out_fmt, output, 3 bits: format code, where 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z.
REQ-014 The block SHALL have port out_target, output, XLEN bits: in_pc + out_imm, modulo 2^XLEN.
REQ-015 The block SHALL have port out_illegal, output, 1 bit: the opcode is not recognised.
REQ-016 The block SHALL have port out_insn, output, 32 bits, and port out_pc, output, XLEN bits: pass-through copies of the accepted instruction and PC.

Function
REQ-017 Opcodes SHALL map to formats as follows: 0110111 and 0010111 to U; 1101111 to J; 1100111, 0000011, 0010011 and 0011011 (the last only when XLEN=64) to I; 0100011 to S; 1100011 to B; 0110011, 0111011 (XLEN=64 only), 0001111 and 1110011 to NONE, except as stated in REQ-018.
REQ-018 When EN_CSR=1, opcode 1110011 with insn[14]=1 SHALL map to Z, with out_imm = zero-extended insn[19:15].
REQ-019 Immediates SHALL use the RISC-V bit placement: I = insn[31:20]; S = {insn[31:25], insn[11:7]}; B = {insn[31], insn[7], insn[30:25], insn[11:8], 0}; U = {insn[31:12], 12'b0}; J = {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
REQ-020 Every I, S, B, U and J immediate SHALL be sign-extended from insn[31] to XLEN, including U when XLEN=64.
REQ-021 For format NONE, out_imm SHALL be 0.
REQ-022 out_illegal SHALL be 1, with out_fmt=NONE and out_imm=0, for any opcode not listed in REQ-017, including any opcode with insn[1:0] not equal to 11.
REQ-023 out_target SHALL always be computed as pc + imm with carry-out discarded; consumers ignore it for formats where it has no meaning.
REQ-024 Latency SHALL be exactly 1 cycle: a transfer accepted at edge N is presented with out_valid=1 after edge N.
REQ-025 Buffering SHALL be a 2-entry skid buffer consisting of a main register and a skid register.
REQ-026 in_ready SHALL be driven directly from a flop: in_ready = !skid_valid.
REQ-027 An input transfer SHALL occur when in_valid && in_ready.
REQ-028 An output transfer SHALL occur when out_valid && out_ready.
REQ-029 If the main register is empty, or drains in the same cycle, an accepted entry SHALL be written to the main register.
REQ-030 If the main register is full and does not drain, an accepted entry SHALL be written to the skid register.
REQ-031 When the main register drains while the skid register is full, the skid contents SHALL move to the main register, and in_ready SHALL return to 1 on the next cycle.
REQ-032 Ordering SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-033 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-034 flush SHALL clear both valid bits at the edge, and an input transfer offered in the same cycle SHALL be discarded; flush has priority over all other updates.
REQ-035 Simultaneous input and output transfers with one entry held SHALL leave the occupancy at 1.

Reset
REQ-036 On rst=1 at an edge: out_valid=0, skid_valid=0, in_ready=1 from the next cycle, and out_imm, out_target, out_fmt, out_illegal, out_insn and out_pc all 0.
REQ-037 rst SHALL override flush and any transfer.
REQ-038 Reset asserted mid-stream SHALL discard all held entries.

Verification
REQ-039 XLEN=32, insn 0xFFF00093 (addi x1,x0,-1), pc 0x100 -> one cycle later fmt=1, imm=0xFFFFFFFF, target=0x000000FF.
REQ-040 XLEN=64, insn 0x800000B7 (lui) -> fmt=4, imm=0xFFFFFFFF80000000; insn 0xFE000EE3 (beq, offset -4), pc 0x1000 -> fmt=3, imm=-4, target=0xFFC.
REQ-041 out_ready=0 while 3 back-to-back inputs are offered -> 2 accepted, in_ready=0 on the 3rd; then out_ready=1 -> entries emerge in order and in_ready rises again.
REQ-042 EN_CSR=1, insn 0x3400D073 (csrrwi, zimm=1) -> fmt=6, imm=1; EN_CSR=0, same insn -> fmt=0, imm=0, illegal=0; insn 0x0000007F -> illegal=1.
REQ-043 flush asserted with 2 entries held plus one offered -> the next cycle has out_valid=0 and in_ready=1, and none of the three entries ever appears.
REQ-044 rst pulsed for 1 cycle mid-stream -> all outputs 0 and in_ready=1, with no stale entry afterwards.
